counter_ctrl: RTL and testbench
===============================

// Module: counter_ctrl
// PURPOSE
//  Command-driven sequencer for the catalog up/down counter. It accepts a job
//  (direction, step count, optional clear) over a valid/ready handshake.
//  It drives the counter's rst/en/up_down for exactly that many enabled cycles,
//  then reports the counter's final value with a one-cycle done pulse.
//  Sits beside the counter; the parent instantiates both and wires cnt_* to it.
// PARAMETERS
//  N         8     counter width; width of cmd_steps, cnt_q, result
//  UP_LEVEL  1'b1  level of cnt_up_down that makes the counter count up
// PORTS
//  clk          in   1  single clock, all logic on posedge
//  rst          in   1  synchronous, active-high reset
//  cmd_valid    in   1  job request
//  cmd_ready    out  1  high only in IDLE and not in reset
//  cmd_dir      in   1  1 = up, 0 = down
//  cmd_clr      in   1  1 = zero the counter before counting
//  cmd_steps    in   N  number of enabled count cycles (0 allowed)
//  pause        in   1  hold counting (cnt_en low), state kept
//  abort        in   1  terminate active job early
//  cnt_q        in   N  counter output, fed back
//  cnt_rst      out  1  counter reset, active-high, synchronous
//  cnt_en       out  1  counter enable
//  cnt_up_down  out  1  counter direction
//  busy         out  1  state != IDLE
//  done         out  1  one-cycle pulse, job finished
//  aborted      out  1  valid with done; 1 if the job ended by abort
//  result       out  N  cnt_q captured at job end, held until the next done
// BEHAVIOUR
//  - FSM states: IDLE, CLEAR, RUN, FINISH.
//  - Reset: state=IDLE. done=0, aborted=0, result=0, cnt_en=0, cmd_ready=0.
//    cnt_rst = rst | (state==CLEAR), so system reset also clears the counter.
//  - IDLE: accept on cmd_valid && cmd_ready. Latch dir, clr, steps into
//    remaining. Next state is CLEAR if clr; else RUN if steps!=0; else FINISH.
//  - CLEAR: exactly 1 cycle with cnt_rst=1 and cnt_en=0.
//    Next state is RUN if steps!=0, else FINISH.
//  - RUN: cnt_en = !pause && !abort (combinational).
//    cnt_up_down = dir ? UP_LEVEL : ~UP_LEVEL, held for the whole job.
//    remaining decrements on each cnt_en cycle. The cycle where cnt_en=1 and
//    remaining==1 is the last one; next state is FINISH.
//  - FINISH: 1 cycle with cnt_en=0; cnt_q is now final.
//    At the closing edge, result<=cnt_q and done<=1 (pulse).
//    Next state is IDLE, so done, result and cmd_ready are high together.
//  - Latency: the accept edge is followed by [1 CLEAR] + steps enabled cycles
//    + pause cycles + 1 FINISH cycle. done appears in the first IDLE cycle.
//  - Abort: takes effect in CLEAR or RUN. That cycle has cnt_en=0; next state
//    is FINISH and aborted=1 with done. Abort wins over pause.
//    Abort is ignored in IDLE and FINISH. Pause is ignored outside RUN.
//  - steps=0: no enabled cycles; result = cnt_q as found (0 if clr).
//  - Wrap-around belongs to the counter and is not detected here:
//    down from 0 gives 2^N-1.
//  - cmd_valid while busy is not accepted. The requester holds it; it is
//    accepted in the IDLE cycle that carries done.
//  - rst mid-job: next cycle IDLE; cnt_en drops the same cycle; no done.
//  - remaining is N bits; the arithmetic is a plain decrement and never
//    underflows because of the ==1 exit.
// STRUCTURE
//  - counter_ctrl_pkg: typedef enum logic [1:0] {IDLE,CLEAR,RUN,FINISH}
//    ctrl_state_t.
//  - One registered-state always_ff, one next-state/output always_comb,
//    a datapath always_ff for latches, remaining and result.
//  - No sub-module: the counter stays external so it can be shared or
//    replaced by the parent.
// TESTING (N=8, bench instantiates counter_ctrl + counter)
//  1. rst 2 cycles, then job up/clr/steps=5: ready=0 during rst; CLEAR 1 cycle;
//     cnt_en high 5 consecutive cycles; done 1 cycle; result=5, aborted=0.
//  2. Follow-on job down/no-clr/steps=3: result=2; done 5 cycles after accept.
//  3. Job up/no-clr/steps=0: cnt_en never high; done 2 cycles after accept;
//     result=2.
//  4. Job up/clr/steps=4 with pause high 2 cycles mid-RUN: 4 enabled cycles
//     spread over 6; result=4.
//  5. Job down/clr/steps=1: wrap; result=8'hFF.
//  6. Job up/clr/steps=10 with abort after 2 enabled cycles: result=2,
//     aborted=1. Then rst mid-RUN: cnt_en=0 during rst, no done,
//     cmd_ready=1 after rst falls.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter job sequencer.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/counter_ctrl.sv
// Command-driven sequencer for an external up/down counter: runs one job of
// cmd_steps enabled cycles, then reports the counter value with a done pulse.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int   N        = 8,
  parameter logic UP_LEVEL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_dir,
  input  logic         cmd_clr,
  input  logic [N-1:0] cmd_steps,
  input  logic         pause,
  input  logic         abort,
  input  logic [N-1:0] cnt_q,
  output logic         cnt_rst,
  output logic         cnt_en,
  output logic         cnt_up_down,
  output logic         busy,
  output logic         done,
  output logic         aborted,
  output logic [N-1:0] result
);

  ctrl_state_t  state;
  ctrl_state_t  state_next;
  logic         dir_q;
  logic         abort_q;
  logic [N-1:0] remaining;
  logic         accept;
  logic         run_en;

  assign cmd_ready   = (state == IDLE) && !rst;
  assign accept      = cmd_valid && cmd_ready;
  assign busy        = (state != IDLE);
  assign cnt_rst     = rst || (state == CLEAR);
  assign cnt_up_down = dir_q ? UP_LEVEL : ~UP_LEVEL;
  // Enable is combinational so pause/abort/rst drop it in the same cycle.
  assign cnt_en      = run_en && !rst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    state_next = state;
    run_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_clr)             state_next = CLEAR;
          else if (cmd_steps != '0) state_next = RUN;
          else                     state_next = FINISH;
        end
      end
      CLEAR: begin
        if (abort || remaining == '0) state_next = FINISH;
        else                          state_next = RUN;
      end
      RUN: begin
        run_en = !pause && !abort;
        if (abort)                                state_next = FINISH;
        else if (run_en && remaining == N'(1))    state_next = FINISH;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q     <= 1'b0;
      abort_q   <= 1'b0;
      remaining <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dir_q     <= cmd_dir;
        remaining <= cmd_steps;
        abort_q   <= 1'b0;
      end
      if ((state == CLEAR || state == RUN) && abort) begin
        abort_q <= 1'b1;
      end
      if (cnt_en) begin
        remaining <= remaining - N'(1);
      end
      if (state == FINISH) begin
        done    <= 1'b1;
        aborted <= abort_q;
        result  <= cnt_q;
      end
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl driving a behavioural up/down counter.
module tb_counter_ctrl;

  localparam int   N        = 8;
  localparam logic UP_LEVEL = 1'b1;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_dir, cmd_clr;
  logic [N-1:0] cmd_steps;
  logic         pause, abort;
  logic [N-1:0] cnt_q;
  logic         cnt_rst, cnt_en, cnt_up_down;
  logic         busy, done, aborted;
  logic [N-1:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_ctrl #(.N(N), .UP_LEVEL(UP_LEVEL)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_clr(cmd_clr), .cmd_steps(cmd_steps),
    .pause(pause), .abort(abort),
    .cnt_q(cnt_q), .cnt_rst(cnt_rst), .cnt_en(cnt_en), .cnt_up_down(cnt_up_down),
    .busy(busy), .done(done), .aborted(aborted), .result(result)
  );

  // Catalog counter stand-in: sync reset, enable, direction.
  always_ff @(posedge clk) begin
    if (cnt_rst)     cnt_q <= '0;
    else if (cnt_en) cnt_q <= (cnt_up_down == UP_LEVEL) ? cnt_q + 8'd1 : cnt_q - 8'd1;
  end

  // Issues one job and watches it to done. Cycle 1 is the first cycle after
  // the accept edge. Called at posedge+2; returns at posedge+2 of the done cycle.
  task automatic run_job(input logic dir, input logic clr, input logic [N-1:0] steps,
                         input int pause_start, input int pause_len, input int abort_after_en,
                         output int en_cnt, output int first_en, output int last_en,
                         output int clear_cyc, output int done_at, output logic rdy_at_done,
                         output logic [N-1:0] res, output logic abt);
    int  wait_cyc;
    bit  abort_sent;
    en_cnt = 0; first_en = -1; last_en = -1; clear_cyc = 0; done_at = -1;
    rdy_at_done = 1'b0; res = '0; abt = 1'b0; abort_sent = 0;
    wait_cyc = 0;
    while (!cmd_ready && wait_cyc < 50) begin
      @(posedge clk); #2;
      wait_cyc++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1");
    end
    cmd_dir = dir; cmd_clr = clr; cmd_steps = steps; cmd_valid = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      pause = (pause_len > 0) && (cyc >= pause_start) && (cyc < pause_start + pause_len);
      abort = 1'b0;
      if (abort_after_en >= 0 && !abort_sent && en_cnt == abort_after_en && busy) begin
        abort = 1'b1;
        abort_sent = 1;
      end
      #1;
      if (cnt_en) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
      if (cnt_rst) clear_cyc++;
      if (done) begin
        done_at = cyc; rdy_at_done = cmd_ready; res = result; abt = aborted;
        break;
      end
    end
    pause = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #2;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", cmd_ready); end
    end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (aborted !== 1'b0)  begin errors++; $display("FAIL reset_aborted: got %0b expected 0", aborted); end
    checks++; if (result !== 8'h00)  begin errors++; $display("FAIL reset_result: got %0h expected 00", result); end
    checks++; if (cnt_en !== 1'b0)   begin errors++; $display("FAIL reset_cnt_en: got %0b expected 0", cnt_en); end
    checks++; if (cnt_rst !== 1'b1)  begin errors++; $display("FAIL reset_cnt_rst: got %0b expected 1", cnt_rst); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %0b expected 1", cmd_ready); end
  endtask

  task automatic test_up_clear();
    int en, fe, le, cl, dn; logic rdy, ab; logic [N-1:0] r;
    run_job(1'b1, 1'b1, 8'd5, 0, 0, -1, en, fe, le, cl, dn, rdy, r, ab);
    checks++; if (cl != 1)         begin errors++; $display("FAIL t1_clear_cycles: got %0d expected 1", cl); end
    checks++; if (en != 5)         begin errors++; $display("FAIL t1_en_count: got %0d expected 5", en); end
    checks++; if (le - fe + 1 != 5) begin errors++; $display("FAIL t1_en_span: got %0d expected 5", le - fe + 1); end
    checks++; if (dn != 8)         begin errors++; $display("FAIL t1_done_at: got %0d expected 8", dn); end
    checks++; if (r !== 8'd5)      begin errors++; $display("FAIL t1_result: got %0d expected 5", r); end
    checks++; if (ab !== 1'b0)     begin errors++; $display("FAIL t1_aborted: got %0b expected 0", ab); end
    checks++; if (rdy !== 1'b1)    begin errors++; $display("FAIL t1_ready_with_done: got %0b expected 1", rdy); end
    @(posedge clk); #2;
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL t1_done_pulse: got %0b expected 0", done); end
    checks++; if (result !== 8'd5) begin errors++; $display("FAIL t1_result_held: got %0d expected 5", result); end
  endtask

  task automatic test_down_noclr();
    int en, fe, le, cl, dn; logic rdy, ab; logic [N-1:0] r;
    run_job(1'b0, 1'b0, 8'd3, 0, 0, -1, en, fe, le, cl, dn, rdy, r, ab);
    checks++; if (en != 3)      begin errors++; $display("FAIL t2_en_count: got %0d expected 3", en); end
    checks++; if (cl != 0)      begin errors++; $display("FAIL t2_clear_cycles: got %0d expected 0", cl); end
    checks++; if (dn != 5)      begin errors++; $display("FAIL t2_done_at: got %0d expected 5", dn); end
    checks++; if (r !== 8'd2)   begin errors++; $display("FAIL t2_result: got %0d expected 2", r); end
  endtask

  // Starts in the done cycle of the previous job to exercise back-to-back accept.
  task automatic test_back_to_back_zero_steps();
    int en, fe, le, cl, dn; logic rdy, ab; logic [N-1:0] r;
    run_job(1'b1, 1'b0, 8'd0, 0, 0, -1, en, fe, le, cl, dn, rdy, r, ab);
    checks++; if (en != 0)      begin errors++; $display("FAIL t3_en_count: got %0d expected 0", en); end
    checks++; if (dn != 2)      begin errors++; $display("FAIL t3_done_at: got %0d expected 2", dn); end
    checks++; if (r !== 8'd2)   begin errors++; $display("FAIL t3_result: got %0d expected 2", r); end
  endtask

  task automatic test_pause();
    int en, fe, le, cl, dn; logic rdy, ab; logic [N-1:0] r;
    run_job(1'b1, 1'b1, 8'd4, 3, 2, -1, en, fe, le, cl, dn, rdy, r, ab);
    checks++; if (en != 4)          begin errors++; $display("FAIL t4_en_count: got %0d expected 4", en); end
    checks++; if (le - fe + 1 != 6) begin errors++; $display("FAIL t4_en_span: got %0d expected 6", le - fe + 1); end
    checks++; if (dn != 9)          begin errors++; $display("FAIL t4_done_at: got %0d expected 9", dn); end
    checks++; if (r !== 8'd4)       begin errors++; $display("FAIL t4_result: got %0d expected 4", r); end
  endtask

  task automatic test_wrap();
    int en, fe, le, cl, dn; logic rdy, ab; logic [N-1:0] r;
    run_job(1'b0, 1'b1, 8'd1, 0, 0, -1, en, fe, le, cl, dn, rdy, r, ab);
    checks++; if (en != 1)      begin errors++; $display("FAIL t5_en_count: got %0d expected 1", en); end
    checks++; if (dn != 4)      begin errors++; $display("FAIL t5_done_at: got %0d expected 4", dn); end
    checks++; if (r !== 8'hFF)  begin errors++; $display("FAIL t5_result: got %0h expected ff", r); end
  endtask

  task automatic test_abort_and_rst();
    int en, fe, le, cl, dn; logic rdy, ab; logic [N-1:0] r;
    int seen_done;
    run_job(1'b1, 1'b1, 8'd10, 0, 0, 2, en, fe, le, cl, dn, rdy, r, ab);
    checks++; if (en != 2)      begin errors++; $display("FAIL t6_en_count: got %0d expected 2", en); end
    checks++; if (dn != 6)      begin errors++; $display("FAIL t6_done_at: got %0d expected 6", dn); end
    checks++; if (r !== 8'd2)   begin errors++; $display("FAIL t6_result: got %0d expected 2", r); end
    checks++; if (ab !== 1'b1)  begin errors++; $display("FAIL t6_aborted: got %0b expected 1", ab); end

    // Second job, reset during RUN.
    cmd_dir = 1'b1; cmd_clr = 1'b1; cmd_steps = 8'd10; cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (cnt_en !== 1'b0)    begin errors++; $display("FAIL t6_rst_cnt_en: got %0b expected 0", cnt_en); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL t6_rst_ready: got %0b expected 0", cmd_ready); end
    checks++; if (cnt_rst !== 1'b1)   begin errors++; $display("FAIL t6_rst_cnt_rst: got %0b expected 1", cnt_rst); end
    @(posedge clk); #2;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL t6_rst_busy: got %0b expected 0", busy); end
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL t6_ready_after_rst: got %0b expected 1", cmd_ready); end
    checks++; if (cnt_q !== 8'd0)     begin errors++; $display("FAIL t6_cnt_cleared: got %0d expected 0", cnt_q); end
    seen_done = 0;
    repeat (6) begin
      @(posedge clk); #2;
      if (done) seen_done++;
    end
    checks++; if (seen_done != 0)     begin errors++; $display("FAIL t6_no_done: got %0d expected 0", seen_done); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_clr = 1'b0;
    cmd_steps = '0; pause = 1'b0; abort = 1'b0;
    test_reset();
    test_up_clear();
    test_down_noclr();
    test_back_to_back_zero_steps();
    test_pause();
    test_wrap();
    test_abort_and_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
